// File: rtl/comps_in_cond.sv
// Debounces five synchronized GPIO levels feeding the comparator inputs, with change strobes and startup valid.
// Optional rejected-glitch counter enabled by COMPS_IN_GLITCH_CNT_EN; otherwise glitch_cnt_o is tied to 0.
module comps_in_cond #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic [4:0]  raw_i,
  output logic        a_o,
  output logic        b1_o,
  output logic        b2_o,
  output logic        c1_o,
  output logic        c2_o,
  output logic [4:0]  chg_o,
  output logic        valid_o,
  output logic [15:0] glitch_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [8:0]       START_MAX = 9'(DEB_CYCLES + 1);

  logic [4:0]       s1_q, s1_d, s2_q, s2_d;
  logic [4:0]       deb_q, deb_d, chg_q, chg_d, flip;
  logic [CNT_W-1:0] cnt_q [5];
  logic [CNT_W-1:0] cnt_d [5];
  logic [8:0]       start_q, start_d;
  logic             valid_q, valid_d;

  always_comb begin
    s1_d  = raw_i;
    s2_d  = s1_q;
    deb_d = deb_q;
    flip  = '0;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        // Terminal count: accept the new level instead of counting further.
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = s2_q[i];
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    start_d = start_q;
    valid_d = valid_q;
    if (!valid_q) begin
      if (start_q == START_MAX) valid_d = 1'b1;
      else                      start_d = start_q + 1'b1;
    end
    // Gate with the next valid so a strobe never appears while valid_o is low.
    chg_d = flip & {5{valid_d}};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      chg_q   <= '0;
      start_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      chg_q   <= chg_d;
      start_q <= start_d;
      valid_q <= valid_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef COMPS_IN_GLITCH_CNT_EN
  logic [4:0]  abort;
  logic [2:0]  n_abort;
  logic [16:0] glitch_sum;
  logic [15:0] glitch_q, glitch_d;

  always_comb begin
    abort   = '0;
    n_abort = '0;
    for (int i = 0; i < 5; i++) begin
      abort[i] = (s2_q[i] == deb_q[i]) && (cnt_q[i] != '0);
      n_abort  = n_abort + 3'(abort[i]);
    end
    glitch_sum = {1'b0, glitch_q} + 17'(n_abort);
    glitch_d   = glitch_sum[16] ? 16'hFFFF : glitch_sum[15:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) glitch_q <= '0;
    else           glitch_q <= glitch_d;
  end

  assign glitch_cnt_o = glitch_q;
`else
  assign glitch_cnt_o = '0;
`endif

  assign a_o     = deb_q[0];
  assign b1_o    = deb_q[1];
  assign b2_o    = deb_q[2];
  assign c1_o    = deb_q[3];
  assign c2_o    = deb_q[4];
  assign chg_o   = chg_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_comps_in_cond.sv
// Directed bench for comps_in_cond at DEB_CYCLES=4; glitch expectations follow COMPS_IN_GLITCH_CNT_EN.
module tb_comps_in_cond;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [4:0]  raw_i    = '0;
  logic        a_o, b1_o, b2_o, c1_o, c2_o, valid_o;
  logic [4:0]  chg_o;
  logic [15:0] glitch_cnt_o;
  logic [4:0]  deb;

  int errors = 0;
  int checks = 0;

`ifdef COMPS_IN_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  comps_in_cond #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_n     (wb_rst_n),
    .raw_i        (raw_i),
    .a_o          (a_o),
    .b1_o         (b1_o),
    .b2_o         (b2_o),
    .c1_o         (c1_o),
    .c2_o         (c2_o),
    .chg_o        (chg_o),
    .valid_o      (valid_o),
    .glitch_cnt_o (glitch_cnt_o)
  );

  assign deb = {c2_o, c1_o, b2_o, b1_o, a_o};

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [15:0] exp_gc(input int n);
    return GC_EN ? 16'(n) : 16'h0000;
  endfunction

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_reset;
    wb_rst_n = 1'b0;
    tick();
    tick();
    wb_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset;
    raw_i    = '0;
    wb_rst_n = 1'b0;
    #3;
    checks++; if (deb !== 5'b0)           begin errors++; $display("FAIL rst_deb: got %b expected 00000", deb); end
    checks++; if (chg_o !== 5'b0)         begin errors++; $display("FAIL rst_chg: got %b expected 00000", chg_o); end
    checks++; if (valid_o !== 1'b0)       begin errors++; $display("FAIL rst_valid: got %b expected 0", valid_o); end
    checks++; if (glitch_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_glitch: got %h expected 0000", glitch_cnt_o); end
    tick();
    wb_rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (valid_o !== (i >= 6)) begin errors++; $display("FAIL valid_edge%0d: got %b expected %b", i, valid_o, (i >= 6)); end
      checks++; if (deb !== 5'b0 || chg_o !== 5'b0) begin errors++; $display("FAIL idle_out%0d: got deb=%b chg=%b expected 0", i, deb, chg_o); end
    end
  endtask

  task automatic test_single_rise;
    raw_i = 5'b00001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (a_o !== 1'b0 || chg_o !== 5'b0) begin errors++; $display("FAIL rise_early%0d: got a=%b chg=%b expected 0", i, a_o, chg_o); end
    end
    tick();
    checks++; if (a_o !== 1'b1)         begin errors++; $display("FAIL rise_a: got %b expected 1", a_o); end
    checks++; if (chg_o !== 5'b00001)   begin errors++; $display("FAIL rise_chg: got %b expected 00001", chg_o); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (a_o !== 1'b1 || chg_o !== 5'b0) begin errors++; $display("FAIL rise_after%0d: got a=%b chg=%b expected a=1 chg=0", i, a_o, chg_o); end
    end
  endtask

  task automatic test_glitch;
    raw_i = 5'b00101;
    for (int i = 0; i < 3; i++) tick();
    raw_i = 5'b00001;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (b2_o !== 1'b0 || chg_o !== 5'b0) begin errors++; $display("FAIL glitch_out%0d: got b2=%b chg=%b expected 0", i, b2_o, chg_o); end
    end
    checks++; if (glitch_cnt_o !== exp_gc(1)) begin errors++; $display("FAIL glitch_cnt: got %0d expected %0d", glitch_cnt_o, exp_gc(1)); end
  endtask

  task automatic test_simultaneous;
    raw_i = 5'b00000;
    for (int i = 0; i < 5; i++) tick();
    tick();
    checks++; if (a_o !== 1'b0 || chg_o !== 5'b00001) begin errors++; $display("FAIL fall_a: got a=%b chg=%b expected a=0 chg=00001", a_o, chg_o); end
    raw_i = 5'b11111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (deb !== 5'b0 || chg_o !== 5'b0) begin errors++; $display("FAIL all_early%0d: got deb=%b chg=%b expected 0", i, deb, chg_o); end
    end
    tick();
    checks++; if (deb !== 5'b11111)   begin errors++; $display("FAIL all_deb: got %b expected 11111", deb); end
    checks++; if (chg_o !== 5'b11111) begin errors++; $display("FAIL all_chg: got %b expected 11111", chg_o); end
    tick();
    checks++; if (chg_o !== 5'b0)     begin errors++; $display("FAIL all_chg_once: got %b expected 00000", chg_o); end
    raw_i = 5'b00000;
    tick();
    tick();
    raw_i = 5'b11111;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (deb !== 5'b11111 || chg_o !== 5'b0) begin errors++; $display("FAIL dip_out%0d: got deb=%b chg=%b expected deb=11111 chg=0", i, deb, chg_o); end
    end
    checks++; if (glitch_cnt_o !== exp_gc(6)) begin errors++; $display("FAIL dip_glitch: got %0d expected %0d", glitch_cnt_o, exp_gc(6)); end
  endtask

  task automatic test_reset_mid;
    raw_i = 5'b00000;
    apply_reset();
    raw_i = 5'b10000;
    for (int i = 0; i < 3; i++) tick();
    wb_rst_n = 1'b0;
    #1;
    checks++; if (c2_o !== 1'b0 || chg_o !== 5'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst: got c2=%b chg=%b valid=%b expected 0", c2_o, chg_o, valid_o); end
    tick();
    tick();
    wb_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++; if (c2_o !== (i >= 6)) begin errors++; $display("FAIL mid_c2_edge%0d: got %b expected %b", i, c2_o, (i >= 6)); end
      checks++; if ((chg_o & ~{5{valid_o}}) !== 5'b0) begin errors++; $display("FAIL mid_chg_early%0d: got chg=%b valid=%b", i, chg_o, valid_o); end
    end
    checks++; if (glitch_cnt_o !== 16'h0) begin errors++; $display("FAIL mid_glitch: got %0d expected 0", glitch_cnt_o); end
  endtask

  task automatic test_saturation;
    raw_i = 5'b00000;
    apply_reset();
    for (int i = 0; i < 27000; i++) begin
      raw_i = (i % 2 == 0) ? 5'b11111 : 5'b00000;
      tick();
      if (i == 9) begin
        checks++; if (glitch_cnt_o !== exp_gc(20)) begin errors++; $display("FAIL sat_early: got %0d expected %0d", glitch_cnt_o, exp_gc(20)); end
      end
      if (i == 25999) begin
        checks++; if (glitch_cnt_o !== exp_gc(64995)) begin errors++; $display("FAIL sat_mid: got %0d expected %0d", glitch_cnt_o, exp_gc(64995)); end
      end
      checks++; if (deb !== 5'b0 || chg_o !== 5'b0) begin errors++; $display("FAIL sat_out%0d: got deb=%b chg=%b expected 0", i, deb, chg_o); end
    end
    raw_i = 5'b00000;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (glitch_cnt_o !== exp_gc(65535)) begin errors++; $display("FAIL sat_hold: got %0d expected %0d", glitch_cnt_o, exp_gc(65535)); end
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comps_in_cond.md
COMPS_IN_COND -- requirements
Module: comps_in_cond

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable cycles required before a debounced input changes; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of each per-bit debounce counter.
REQ-003 Clocking and reset are fixed: one clock, wb_clk_i; reset wb_rst_n, asynchronous, active-low.
REQ-004 SHALL have port wb_clk_i, input, 1 bit: sole clock, all state rising-edge.
REQ-005 SHALL have port wb_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port raw_i, input, 5 bits: raw GPIO levels, bit0=a, bit1=b1, bit2=b2, bit3=c1, bit4=c2.
REQ-007 SHALL have ports a_o, b1_o, b2_o, c1_o and c2_o, outputs, 1 bit each: debounced levels that feed the comparator block inputs a, b1, b2, c1 and c2.
REQ-008 SHALL have port chg_o, output, 5 bits: one-cycle strobe per bit when that debounced level changes.
REQ-009 SHALL have port valid_o, output, 1 bit: debounced outputs meaningful since reset.
REQ-010 SHALL have port glitch_cnt_o, output, 16 bits: count of rejected glitches.

Function
REQ-011 Each raw_i bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Per bit, while s2 != debounced value, the counter SHALL increment by 1 per cycle.
REQ-013 Per bit, the counter SHALL clear to 0 in the cycle s2 == debounced value, whatever its current count.
REQ-014 When the counter == DEB_CYCLES-1 and s2 still differs, at the next edge: the debounced value SHALL take s2, the matching chg_o bit SHALL pulse high for exactly one cycle, and the counter SHALL clear.
REQ-015 Latency: a raw level captured into s1 at edge N, held stable, SHALL appear on the debounced output and chg_o at edge N+DEB_CYCLES+1.
REQ-016 A difference lasting fewer than DEB_CYCLES consecutive s2 cycles SHALL leave output and chg_o unchanged.
REQ-017 Glitch abort: a cycle where the counter is nonzero and s2 returns equal to the debounced value SHALL be counted as one abort for that bit.
REQ-018 The five bits SHALL be fully independent; simultaneous changes on several bits SHALL produce simultaneous chg_o pulses.
REQ-019 The counter SHALL never exceed DEB_CYCLES-1; no wrap-around.
REQ-020 valid_o SHALL go high at the (DEB_CYCLES+2)th rising edge after wb_rst_n deasserts, then stay high until reset; implemented with a saturating startup counter.
REQ-021 Before valid_o is high, debounce SHALL operate normally and chg_o SHALL be forced to 0.

Reset
REQ-022 On wb_rst_n low, asynchronously: s1, s2, debounced outputs, chg_o, all counters, valid_o and glitch_cnt_o SHALL be 0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; after release, debounce SHALL restart from 0 with no chg_o pulse.

Configuration
REQ-024 With COMPS_IN_GLITCH_CNT_EN defined: on every cycle, glitch_cnt_o SHALL increment by the number of bits aborting that cycle (0..5), saturating at 16'hFFFF and never wrapping.
REQ-025 With COMPS_IN_GLITCH_CNT_EN undefined: glitch_cnt_o SHALL be constant 0 and no counter logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification (DEB_CYCLES=4, COMPS_IN_GLITCH_CNT_EN defined unless noted)
REQ-026 Reset release, raw_i=0 -> all outputs 0; valid_o rises at edge 6 after release.
REQ-027 raw_i[0] 0->1 captured at edge N, held -> a_o=1 and chg_o=5'b00001 for one cycle at edge N+5; no further pulse.
REQ-028 raw_i[2] high for 3 cycles, then low -> b2_o stays 0, chg_o stays 0, glitch_cnt_o = 1.
REQ-029 raw_i 0->5'b11111 in one cycle, held -> all five outputs rise on the same edge, chg_o=5'b11111 for one cycle; then a 2-cycle pulse to 0 on all bits -> glitch_cnt_o += 5.
REQ-030 wb_rst_n pulsed low 2 cycles into a debounce of raw_i[4] -> c2_o=0 after release, then rises exactly 5 edges after s1 first recaptures the high level; no chg_o before valid_o.
REQ-031 Saturation: force >65535 glitches -> glitch_cnt_o holds at 16'hFFFF; with COMPS_IN_GLITCH_CNT_EN undefined, same stimulus -> glitch_cnt_o = 0 throughout.
